// File: rtl/ctrl_pkg.sv
// ============================================================================
// ctrl_pkg : opcodes, instruction classes, step and condition constants
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctrl_pkg;

  localparam logic [4:0] OP_ALU       = 5'b00000;
  localparam logic [4:0] OP_LHI       = 5'b00001;
  localparam logic [4:0] OP_LLI       = 5'b00010;
  localparam logic [4:0] OP_LDRRI     = 5'b00011;
  localparam logic [4:0] OP_LDRRR     = 5'b00100;
  localparam logic [4:0] OP_STRRI     = 5'b00101;
  localparam logic [4:0] OP_STRRR_CMP = 5'b00110;
  localparam logic [4:0] OP_ADDI      = 5'b00111;
  localparam logic [4:0] OP_SUBI      = 5'b01000;
  localparam logic [4:0] OP_MOV       = 5'b01011;
  localparam logic [4:0] OP_JMP       = 5'b10000;
  localparam logic [4:0] OP_JAL       = 5'b10001;
  localparam logic [4:0] OP_JALR      = 5'b10010;
  localparam logic [4:0] OP_JR        = 5'b10011;
  localparam logic [4:0] OP_BCOND     = 5'b11000;
  localparam logic [4:0] OP_BAL       = 5'b11001;
  localparam logic [4:0] OP_SYS       = 5'b11100;

  // InsL sub-function selectors for the shared opcodes
  localparam logic [1:0] FN_STR = 2'b00;
  localparam logic [1:0] FN_CMP = 2'b01;
  localparam logic [1:0] FN_OUT = 2'b00;
  localparam logic [1:0] FN_HLT = 2'b01;

  typedef enum logic [3:0] {
    CLS_ALU   = 4'd0,
    CLS_IMM   = 4'd1,
    CLS_LDR   = 4'd2,
    CLS_STR   = 4'd3,
    CLS_CMP   = 4'd4,
    CLS_BCOND = 4'd5,
    CLS_JUMP  = 4'd6,
    CLS_JAL   = 4'd7,
    CLS_OUT   = 4'd8,
    CLS_HLT   = 4'd9,
    CLS_ILL   = 4'd10
  } ins_class_t;

  localparam logic [2:0] STEP_FETCH  = 3'd0;
  localparam logic [2:0] STEP_DECODE = 3'd1;
  localparam logic [2:0] STEP_2      = 3'd2;
  localparam logic [2:0] STEP_3      = 3'd3;
  localparam logic [2:0] STEP_4      = 3'd4;

  localparam logic [2:0] COND_NZ = 3'b000;
  localparam logic [2:0] COND_Z  = 3'b001;
  localparam logic [2:0] COND_C  = 3'b010;
  localparam logic [2:0] COND_NC = 3'b011;

  function automatic logic cond_taken(input logic [2:0] cond, input logic flag_c,
                                      input logic flag_z);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_NZ: taken = ~flag_z;
      COND_Z:  taken = flag_z;
      COND_C:  taken = flag_c;
      COND_NC: taken = ~flag_c;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_class_decode.sv
// ============================================================================
// ctrl_class_decode : combinational {InsM, InsL} -> instruction class
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_class_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] InsM,
  input  logic [1:0] InsL,
  output ins_class_t ins_class
);

  always_comb begin
    ins_class = CLS_ILL;
    case (InsM)
      OP_ALU:                                  ins_class = CLS_ALU;
      OP_LHI, OP_LLI, OP_ADDI, OP_SUBI, OP_MOV: ins_class = CLS_IMM;
      OP_LDRRI, OP_LDRRR:                      ins_class = CLS_LDR;
      OP_STRRI:                                ins_class = CLS_STR;
      OP_STRRR_CMP: begin
        if (InsL == FN_STR)      ins_class = CLS_STR;
        else if (InsL == FN_CMP) ins_class = CLS_CMP;
      end
      OP_BCOND:                                ins_class = CLS_BCOND;
      OP_BAL, OP_JMP, OP_JR:                   ins_class = CLS_JUMP;
      OP_JAL, OP_JALR:                         ins_class = CLS_JAL;
      OP_SYS: begin
        if (InsL == FN_OUT)      ins_class = CLS_OUT;
        else if (InsL == FN_HLT) ins_class = CLS_HLT;
      end
      default:                                 ins_class = CLS_ILL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_step_sequencer.sv
// ============================================================================
// ctrl_step_sequencer : step counter and per-step datapath strobes
// Revision : 1.0
// ============================================================================
`default_nettype none

module ctrl_step_sequencer
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       Rst,
  input  logic [4:0] InsM,
  input  logic [2:0] InsC,
  input  logic [1:0] InsL,
  input  logic       FlagC,
  input  logic       FlagZ,
  input  logic       Mem_ready,
  output logic [2:0] Cnt,
  output logic       IR_load,
  output logic       PC_inc,
  output logic       PC_load,
  output logic       Reg_WB,
  output logic       Mem_req,
  output logic       Mem_we,
  output logic       Out_en,
  output logic       Buff_PC,
  output logic       Halted,
  output logic       Illegal
);

  ins_class_t dec_class;
  ins_class_t cls_q, cls_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] cond_q, cond_d;
  logic       halted_q, halted_d;
  logic       advance;

  ctrl_class_decode u_class_decode (
    .InsM      (InsM),
    .InsL      (InsL),
    .ins_class (dec_class)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      cnt_q    <= STEP_FETCH;
      cls_q    <= CLS_ILL;
      cond_q   <= 3'b000;
      halted_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cls_q    <= cls_d;
      cond_q   <= cond_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    IR_load  = 1'b0;
    PC_inc   = 1'b0;
    PC_load  = 1'b0;
    Reg_WB   = 1'b0;
    Mem_req  = 1'b0;
    Mem_we   = 1'b0;
    Out_en   = 1'b0;
    Buff_PC  = 1'b0;
    Illegal  = 1'b0;
    advance  = 1'b1;
    cls_d    = cls_q;
    cond_d   = cond_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;

    // A halted sequencer freezes: no strobes, no counting, until reset
    if (!Rst && !halted_q) begin
      case (cnt_q)
        STEP_FETCH: begin
          Mem_req = 1'b1;
          IR_load = Mem_ready;
          advance = Mem_ready;
        end
        STEP_DECODE: begin
          PC_inc = 1'b1;
          cls_d  = dec_class;
          cond_d = InsC;
        end
        STEP_2: begin
          case (cls_q)
            CLS_CMP:   Buff_PC = 1'b1;
            CLS_BCOND: begin
              PC_load = cond_taken(cond_q, FlagC, FlagZ);
              Buff_PC = 1'b1;
            end
            CLS_JUMP: begin
              PC_load = 1'b1;
              Buff_PC = 1'b1;
            end
            CLS_JAL:   Reg_WB = 1'b1;
            CLS_OUT: begin
              Out_en  = 1'b1;
              Buff_PC = 1'b1;
            end
            CLS_HLT: begin
              halted_d = 1'b1;
              advance  = 1'b0;
            end
            CLS_ILL: begin
              Illegal = 1'b1;
              Buff_PC = 1'b1;
            end
            default: advance = 1'b1;
          endcase
        end
        STEP_3: begin
          case (cls_q)
            CLS_ALU, CLS_IMM: begin
              Reg_WB  = 1'b1;
              Buff_PC = 1'b1;
            end
            CLS_LDR: begin
              Mem_req = 1'b1;
              advance = Mem_ready;
            end
            CLS_STR: begin
              Mem_req = 1'b1;
              Mem_we  = 1'b1;
              Buff_PC = Mem_ready;
              advance = Mem_ready;
            end
            CLS_JAL: begin
              PC_load = 1'b1;
              Buff_PC = 1'b1;
            end
            default: Buff_PC = 1'b1;
          endcase
        end
        STEP_4: begin
          Reg_WB  = (cls_q == CLS_LDR);
          Buff_PC = 1'b1;
        end
        // Unreachable step values fall back to fetch
        default: Buff_PC = 1'b1;
      endcase

      if (Buff_PC)      cnt_d = STEP_FETCH;
      else if (advance) cnt_d = cnt_q + 3'd1;
    end
  end

  assign Cnt    = cnt_q;
  assign Halted = halted_q;

endmodule

`default_nettype wire
